multi_mode_ff_bank: RTL
=======================

Name: multi_mode_ff_bank

Overview:
- WIDTH-bit bank of independent flip-flops sharing one clock.
- Runtime-selectable mode (SR, JK, D, T), plus synchronous parallel load and enable.
- The illegal SR input combination is defined: the bit holds its value and a sticky per-bit error flag and a saturating error counter are updated.
- Drop-in successor for single-bit SR storage cells in control and status paths.

Parameters:
- WIDTH, 4, number of flip-flop bits.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.
- CNT_W, 8, width of the illegal-event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  update enable for the mode logic.
- mode  input  2  00=SR, 01=JK, 10=D, 11=T.
- a  input  WIDTH  per-bit S / J / D / T input, depending on mode.
- b  input  WIDTH  per-bit R / K input; ignored in D and T modes.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  data for parallel load.
- clr_err  input  1  clears err_flag and err_cnt.
- q  output  WIDTH  flip-flop state.
- qb  output  WIDTH  ~q, combinational.
- chg  output  WIDTH  registered; bit i = 1 for the cycle after q[i] changed value.
- err_flag  output  WIDTH  sticky per-bit illegal-SR flag.
- err_cnt  output  CNT_W  count of cycles with at least one illegal SR bit; saturates.

Behaviour:
- Priority per rising edge: rst_n=0 > load=1 > en=1 > hold.
- Reset (rst_n=0 at edge): q=RESET_VAL, chg=0, err_flag=0, err_cnt=0. Reset overrides all other inputs, including mid-operation.
- Load (load=1): q=load_val regardless of en and mode. No illegal detection occurs in a load cycle.
- en=0, load=0: q holds; chg=0; no error updates.
- en=1, load=0, per bit i, next q[i] by mode:
  - SR: ab=00 hold, 01 -> 0, 10 -> 1, 11 illegal -> hold (never X).
  - JK: 00 hold, 01 -> 0, 10 -> 1, 11 -> ~q[i].
  - D: q[i]=a[i]; b ignored.
  - T: a[i]=1 -> ~q[i], else hold; b ignored.
- mode is sampled every edge. A mode change takes effect on the same edge; no pipeline and no mode state.
- chg[i] is registered as (next q[i] != current q[i]) on every non-reset edge, including load edges. Latency: chg is visible together with the new q.
- Illegal event: en=1, load=0, mode=SR, a[i]=b[i]=1. It sets err_flag[i].
- err_cnt increments by 1 per cycle with any illegal bit, regardless of how many bits. It saturates at 2^CNT_W-1 and never wraps.
- clr_err=1 clears err_flag and err_cnt, then applies the current cycle's events:
  - err_flag = current illegal bits.
  - err_cnt = 1 if any illegal bit this cycle, else 0.
- qb is always the exact complement of q; never X after reset.
- Before the first reset, state is undefined. The bench must reset first.

Test Plan (WIDTH=4, RESET_VAL=4'b0000, CNT_W=3):
1. Reset and load.
   - rst_n=0 for 2 cycles -> q=0000, qb=1111, chg=0000, err_flag=0000, err_cnt=0.
   - Release, then load=1, load_val=1010 -> q=1010, chg=1010.
2. SR mode, en=1, from q=1010.
   - a=0101, b=1000 -> q=0111, chg=1101, err_flag=0000.
   - Then a=1100, b=1100 -> q=0111 (held), err_flag=1100, err_cnt=1, chg=0000.
3. JK then T.
   - JK, q=0111, a=1111, b=1111 -> q=1000.
   - T, a=1001 -> q=0001.
   - D, a=0110, b=1111 -> q=0110.
4. Saturation and clear.
   - Hold an illegal SR input (a=b=0001) for 9 cycles -> err_cnt stops at 7.
   - clr_err=1 with the illegal input still present -> err_flag=0001, err_cnt=1.
   - clr_err=1 with a=b=0 -> err_flag=0000, err_cnt=0.
5. Priority.
   - en=0, load=0 with changing a/b -> q unchanged, chg=0000.
   - load=1 with en=1, SR, a=b=1111 -> q=load_val, err_cnt unchanged.
   - rst_n=0 together with load=1 -> q=0000 and error state cleared.

Source files
------------

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH independent flip-flops with runtime-selectable SR/JK/D/T behaviour,
// parallel load, per-bit change strobes and illegal-SR error tracking.
module multi_mode_ff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] mode_next;
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] flag_base;
  logic [CNT_W-1:0] cnt_base;

  assign mode_sel = mode_e'(mode);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        mode_next[gi] = q_q[gi];
        unique case (mode_sel)
          // SR 11 is defined as hold so the cell never goes unknown.
          MODE_SR: begin
            if (a[gi] != b[gi]) mode_next[gi] = a[gi];
          end
          MODE_JK: begin
            if (a[gi] && b[gi])       mode_next[gi] = ~q_q[gi];
            else if (a[gi] != b[gi])  mode_next[gi] = a[gi];
          end
          MODE_D:  mode_next[gi] = a[gi];
          MODE_T:  begin
            if (a[gi]) mode_next[gi] = ~q_q[gi];
          end
          default: mode_next[gi] = q_q[gi];
        endcase
      end

      assign illegal[gi] = en && !load && (mode_sel == MODE_SR) && a[gi] && b[gi];
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (load)    q_d = load_val;
    else if (en) q_d = mode_next;
  end

  assign chg_d = q_d ^ q_q;

  // Clear first, then fold in this cycle's events so a clear never drops a fresh error.
  always_comb begin
    flag_base  = clr_err ? '0 : err_flag_q;
    cnt_base   = clr_err ? '0 : err_cnt_q;
    err_flag_d = flag_base | illegal;
    err_cnt_d  = cnt_base;
    if ((|illegal) && (cnt_base != CNT_MAX)) err_cnt_d = cnt_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q        <= RESET_VAL;
      chg_q      <= '0;
      err_flag_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      q_q        <= q_d;
      chg_q      <= chg_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign q        = q_q;
  assign qb       = ~q_q;
  assign chg      = chg_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;

endmodule
